// File: rtl/hidden_ram_arbiter.sv
// Hidden-layer RAM arbiter: one writer, one scoreboard-gated reader.
// Define HIDDEN_RAM_ARB_ROUND_ROBIN_EN for round-robin instead of writer priority.
module hidden_ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   wr_count,
  output logic              all_valid
);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  valid_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              pend;
  logic              rd_elig;
  logic              wr_win;
  logic              set_new;

  assign rd_elig = rd_req & valid[rd_addr];

`ifdef HIDDEN_RAM_ARB_ROUND_ROBIN_EN
  logic rd_turn;

  // Reader only wins a contested cycle when it holds the turn
  assign wr_win = wr_req & ~(rd_elig & rd_turn);

  always_ff @(posedge clk) begin
    if (rst)         rd_turn <= 1'b0;
    else if (wr_gnt) rd_turn <= 1'b1;
    else if (rd_gnt) rd_turn <= 1'b0;
  end
`else
  assign wr_win = wr_req;
`endif

  assign wr_gnt = ~rst & wr_win;
  assign rd_gnt = ~rst & rd_elig & ~wr_win;

  assign ram_we   = wr_gnt;
  assign ram_data = wr_data;

  always_comb begin
    ram_addr = addr_q;
    unique case (1'b1)
      wr_gnt:  ram_addr = wr_addr;
      rd_gnt:  ram_addr = rd_addr;
      default: ram_addr = addr_q;
    endcase
  end

  assign set_new = wr_gnt & ~valid[wr_addr];

  // Clear first, then a same-cycle write re-marks its entry
  always_comb begin
    valid_nxt = clr ? '0 : valid;
    if (wr_gnt) valid_nxt[wr_addr] = 1'b1;
    if (clr) cnt_nxt = {{ADDR_W{1'b0}}, wr_gnt};
    else     cnt_nxt = cnt + (ADDR_W+1)'(set_new);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      cnt    <= '0;
      addr_q <= '0;
      pend   <= 1'b0;
      data_q <= '0;
    end else begin
      valid  <= valid_nxt;
      cnt    <= cnt_nxt;
      addr_q <= ram_addr;
      pend   <= rd_gnt;
      if (rd_valid) data_q <= ram_q;
    end
  end

  // A read in flight when reset rises is dropped
  assign rd_valid  = pend & ~rst;
  assign rd_data   = rd_valid ? ram_q : data_q;
  assign wr_count  = cnt;
  assign all_valid = (cnt == (ADDR_W+1)'(DEPTH));

endmodule

// File: tb/tb_hidden_ram_arbiter.sv
// Random plus directed bench for hidden_ram_arbiter.
// Reference model tracks written entries and expected RAM contents.
module tb_hidden_ram_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 32;

  logic          clk;
  logic          rst;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          clr;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic [AW:0]   wr_count;
  logic          all_valid;

  hidden_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(N)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .clr(clr),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q),
    .wr_count(wr_count), .all_valid(all_valid)
  );

  logic [DW-1:0] ram [N];

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data;
    ram_q <= ram[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit            written [N];
  logic [DW-1:0] mmem [N];
  bit            pend;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] hold;
  logic [AW-1:0] last_addr;
  bit            turn;
  int            n_chk;
  int            n_bad;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int popc();
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(written[i]);
    return s;
  endfunction

  task automatic step(input bit w,
                      input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd,
                      input bit r,
                      input logic [AW-1:0] ra,
                      input bit c,
                      input bit rs);
    bit eg, erg, elig, ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int pc;
    @(negedge clk);
    wr_req = w; wr_addr = wa; wr_data = wd;
    rd_req = r; rd_addr = ra;
    clr = c; rst = rs;
    #1;
    elig = r && written[ra];
    if (rs) begin
      eg = 0; erg = 0;
    end else begin
`ifdef HIDDEN_RAM_ARB_ROUND_ROBIN_EN
      if (w && elig) begin
        eg = !turn; erg = turn;
      end else begin
        eg = w; erg = elig;
      end
`else
      eg = w; erg = elig && !w;
`endif
    end
    ea = eg ? wa : (erg ? ra : last_addr);
    ev = pend && !rs;
    ed = ev ? pend_data : hold;
    pc = popc();
    check("wr_gnt", 32'(wr_gnt), 32'(eg));
    check("rd_gnt", 32'(rd_gnt), 32'(erg));
    check("ram_we", 32'(ram_we), 32'(eg));
    check("ram_addr", 32'(ram_addr), 32'(ea));
    if (eg) check("ram_data", 32'(ram_data), 32'(wd));
    check("rd_valid", 32'(rd_valid), 32'(ev));
    check("rd_data", 32'(rd_data), 32'(ed));
    check("wr_count", 32'(wr_count), 32'(pc));
    check("all_valid", 32'(all_valid), 32'(pc == N));
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < N; i++) written[i] = 0;
      pend = 0; hold = '0; last_addr = '0; turn = 0;
    end else begin
      if (ev) hold = pend_data;
      pend = erg;
      pend_data = mmem[ra];
      if (c) for (int i = 0; i < N; i++) written[i] = 0;
      if (eg) begin
        written[wa] = 1;
        mmem[wa] = wd;
      end
      last_addr = ea;
      if (eg) turn = 1;
      else if (erg) turn = 0;
    end
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1; wr_req = 0; rd_req = 0; clr = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      written[i] = 0; mmem[i] = '0;
    end
    pend = 0; pend_data = '0; hold = '0;
    last_addr = '0; turn = 0;
    repeat (2) @(posedge clk);
    step(0, '0, '0, 1, 5'd3, 0, 1);
    // write 3 then read back the next cycle
    step(1, 5'd3, 8'h5A, 0, '0, 0, 0);
    step(0, '0, '0, 1, 5'd3, 0, 0);
    idle();
    // stalled read on an unwritten entry
    repeat (4) step(0, '0, '0, 1, 5'd7, 0, 0);
    step(1, 5'd7, 8'h11, 1, 5'd7, 0, 0);
    step(0, '0, '0, 1, 5'd7, 0, 0);
    idle();
    // contention
    repeat (4) step(1, 5'd12, 8'hC3, 1, 5'd3, 0, 0);
    idle();
    // fill the scoreboard, rewrite, then clear with a write
    step(0, '0, '0, 0, '0, 0, 1);
    for (int i = 0; i < N; i++)
      step(1, AW'(i), DW'(i * 7 + 1), 0, '0, 0, 0);
    step(1, 5'd0, 8'hEE, 0, '0, 0, 0);
    idle();
    step(1, 5'd9, 8'h99, 1, 5'd4, 1, 0);
    idle();
    step(0, '0, '0, 1, 5'd9, 0, 0);
    step(0, '0, '0, 1, 5'd3, 0, 0);
    idle();
    // reset right after a read grant
    step(1, 5'd20, 8'h42, 0, '0, 0, 0);
    step(0, '0, '0, 1, 5'd20, 0, 0);
    step(0, '0, '0, 0, '0, 0, 1);
    step(0, '0, '0, 1, 5'd20, 0, 0);
    idle();
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 1) == 1,
           AW'($urandom), DW'($urandom),
           $urandom_range(0, 2) != 0,
           AW'($urandom),
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 150) == 0);
    end
    idle();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
